// File: rtl/l2_mem_responder.sv
// Main-memory responder for the L2 line-fill/writeback interface: critical-word-first bursts after a fixed latency.
// Optional fill/writeback counters are built when MEM_STATS_EN is defined.
module l2_mem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        addrstb,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        stb,
  output logic        busy,
  output logic        ovr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  localparam int unsigned BL = $clog2(BEATS);
  localparam int unsigned DL = DEPTH_LOG2;
  localparam logic [DL-1:0] LINE_MASK = DL'(BEATS - 1);
  localparam logic [BL-1:0] LAST_BEAT = BL'(BEATS - 1);
  localparam logic [3:0]    LAT_M1    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t        state_q;
  logic          we_q;
  logic [DL-1:0] base_q;
  logic [BL-1:0] start_q;
  logic [BL-1:0] beat_q;
  logic [3:0]    cnt_q;
  logic          stb_q;
  logic          busy_q;
  logic          ovr_q;
  logic [63:0]   rdata_q;

  logic [63:0]   mem [2**DL];

  logic [DL-1:0] req_word;
  logic [DL-1:0] req_base;
  logic [BL-1:0] cur_off_d;
  logic [BL-1:0] nxt_off_d;
  logic [DL-1:0] cur_idx_d;
  logic [DL-1:0] nxt_idx_d;
  logic          last_beat;
  logic          unused_addr_bits;

  assign req_word  = addr[DL+2:3];
  assign req_base  = req_word & ~LINE_MASK;
  assign cur_off_d = start_q + beat_q;
  assign nxt_off_d = cur_off_d + BL'(1);
  assign cur_idx_d = base_q | {{(DL-BL){1'b0}}, cur_off_d};
  assign nxt_idx_d = base_q | {{(DL-BL){1'b0}}, nxt_off_d};
  assign last_beat = (beat_q == LAST_BEAT);
  assign unused_addr_bits = ^{addr[2:0], addr[31:DL+3]};

  // Array has no reset; a reset edge suppresses the write of the beat in flight.
  always_ff @(posedge clk) begin
    if (reset_n && state_q == S_BURST && we_q)
      mem[cur_idx_d] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      base_q  <= '0;
      start_q <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (addrstb && state_q != S_IDLE)
        ovr_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (addrstb) begin
            we_q    <= we;
            base_q  <= req_base;
            start_q <= req_word[BL-1:0];
            beat_q  <= '0;
            busy_q  <= 1'b1;
            if (LATENCY == 0) begin
              state_q <= S_BURST;
              stb_q   <= 1'b1;
              rdata_q <= we ? '0 : mem[req_word];
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_BURST;
            stb_q   <= 1'b1;
            rdata_q <= we_q ? '0 : mem[cur_idx_d];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_BURST: begin
          if (last_beat) begin
            state_q <= S_IDLE;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
          end else begin
            beat_q  <= beat_q + BL'(1);
            rdata_q <= we_q ? '0 : mem[nxt_idx_d];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == S_BURST && last_beat) begin
      if (we_q) wr_count_q <= wr_count_q + 32'd1;
      else      rd_count_q <= rd_count_q + 32'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

  assign rdata = rdata_q;
  assign stb   = stb_q;
  assign busy  = busy_q;
  assign ovr   = ovr_q;
endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench: instance A (LATENCY=4, BEATS=4) and instance B (LATENCY=0, BEATS=8).
module tb_l2_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        a_addrstb = 1'b0, b_addrstb = 1'b0;
  logic [63:0] a_rdata, b_rdata;
  logic        a_stb, b_stb, a_busy, b_busy, a_ovr, b_ovr;
  logic [31:0] a_rd_count, a_wr_count, b_rd_count, b_wr_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] wd [8];
  logic [63:0] rd [8];
  int first_stb, n_stb, busy_fall;
  logic [63:0] exp_rd, exp_wr;

  always #5 clk = ~clk;

  l2_mem_responder #(.LATENCY(4), .BEATS(4), .DEPTH_LOG2(10)) u_a (
    .clk(clk), .reset_n(reset_n), .addrstb(a_addrstb), .we(we), .addr(addr),
    .wdata(wdata), .rdata(a_rdata), .stb(a_stb), .busy(a_busy), .ovr(a_ovr),
    .rd_count(a_rd_count), .wr_count(a_wr_count)
  );

  l2_mem_responder #(.LATENCY(0), .BEATS(8), .DEPTH_LOG2(10)) u_b (
    .clk(clk), .reset_n(reset_n), .addrstb(b_addrstb), .we(we), .addr(addr),
    .wdata(wdata), .rdata(b_rdata), .stb(b_stb), .busy(b_busy), .ovr(b_ovr),
    .rd_count(b_rd_count), .wr_count(b_wr_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current cycle (relative cycle 0) and follows it until busy drops.
  // Outputs are cycle offsets from the addrstb cycle; -1 means never seen.
  task automatic xfer(input bit sel, input bit w, input logic [31:0] a,
                      input int pulse_at, input int abort_beat,
                      output int fs, output int ns, output int bf);
    int beat;
    beat = 0; fs = -1; ns = 0; bf = -1;
    we = w; addr = a;
    a_addrstb = !sel;
    b_addrstb = sel;
    for (int i = 1; i <= 40; i++) begin
      tick();
      a_addrstb = (!sel && i == pulse_at);
      b_addrstb = (sel && i == pulse_at);
      if (sel ? b_stb : a_stb) begin
        if (fs < 0) fs = i;
        if (beat < 8) begin
          rd[beat] = sel ? b_rdata : a_rdata;
          wdata    = wd[beat];
        end
        if (beat == abort_beat) reset_n = 1'b0;
        beat++;
        ns++;
      end
      if (!(sel ? b_busy : a_busy)) begin
        bf = i;
        break;
      end
    end
    a_addrstb = 1'b0;
    b_addrstb = 1'b0;
  endtask

  initial begin
    int idle_stb;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_a_busy", {63'd0, a_busy}, 64'd0);
    check("rst_a_stb",  {63'd0, a_stb},  64'd0);
    check("rst_a_ovr",  {63'd0, a_ovr},  64'd0);
    check("rst_a_rdata", a_rdata, 64'd0);
    check("rst_b_busy", {63'd0, b_busy}, 64'd0);
    check("rst_a_rdcnt", {32'd0, a_rd_count}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Writeback of line 0x40, then plain and wrapped fills
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    xfer(1'b0, 1'b1, 32'h0000_0040, -1, -1, first_stb, n_stb, busy_fall);
    check("wb40_first_stb", 64'(first_stb), 64'd5);
    check("wb40_n_stb",     64'(n_stb),     64'd4);
    check("wb40_busy_fall", 64'(busy_fall), 64'd9);

    xfer(1'b0, 1'b0, 32'h0000_0040, -1, -1, first_stb, n_stb, busy_fall);
    check("rd40_first_stb", 64'(first_stb), 64'd5);
    check("rd40_b0", rd[0], 64'h11);
    check("rd40_b1", rd[1], 64'h22);
    check("rd40_b2", rd[2], 64'h33);
    check("rd40_b3", rd[3], 64'h44);

    xfer(1'b0, 1'b0, 32'h0000_0050, -1, -1, first_stb, n_stb, busy_fall);
    check("rd50_b0", rd[0], 64'h33);
    check("rd50_b1", rd[1], 64'h44);
    check("rd50_b2", rd[2], 64'h11);
    check("rd50_b3", rd[3], 64'h22);

    wd[0] = 64'h55; wd[1] = 64'h66; wd[2] = 64'h77; wd[3] = 64'h88;
    xfer(1'b0, 1'b1, 32'h0000_0080, -1, -1, first_stb, n_stb, busy_fall);
    check("wb80_n_stb", 64'(n_stb), 64'd4);

    // Overrun: addrstb during WAIT of a fill
    check("ovr_before", {63'd0, a_ovr}, 64'd0);
    xfer(1'b0, 1'b0, 32'h0000_0040, 2, -1, first_stb, n_stb, busy_fall);
    check("ovr_n_stb",     64'(n_stb),     64'd4);
    check("ovr_busy_fall", 64'(busy_fall), 64'd9);
    check("ovr_set", {63'd0, a_ovr}, 64'd1);
    idle_stb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_stb || a_busy) idle_stb++;
    end
    check("ovr_no_second_burst", 64'(idle_stb), 64'd0);
    check("ovr_sticky", {63'd0, a_ovr}, 64'd1);
`ifdef MEM_STATS_EN
    exp_rd = 64'd3; exp_wr = 64'd2;
`else
    exp_rd = 64'd0; exp_wr = 64'd0;
`endif
    check("stats_rd", {32'd0, a_rd_count}, exp_rd);
    check("stats_wr", {32'd0, a_wr_count}, exp_wr);
    reset_n = 1'b0;
    tick();
    check("ovr_reset", {63'd0, a_ovr}, 64'd0);
    check("stats_rd_reset", {32'd0, a_rd_count}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Reset during the third writeback beat: only beats 0-1 land
    wd[0] = 64'hA1; wd[1] = 64'hA2; wd[2] = 64'hA3; wd[3] = 64'hA4;
    xfer(1'b0, 1'b1, 32'h0000_0080, -1, 2, first_stb, n_stb, busy_fall);
    check("abort_busy_fall", 64'(busy_fall), 64'd8);
    check("abort_stb",  {63'd0, a_stb},  64'd0);
    check("abort_busy", {63'd0, a_busy}, 64'd0);
    reset_n = 1'b1;
    tick();
    xfer(1'b0, 1'b0, 32'h0000_0080, -1, -1, first_stb, n_stb, busy_fall);
    check("abort_rd_b0", rd[0], 64'hA1);
    check("abort_rd_b1", rd[1], 64'hA2);
    check("abort_rd_b2", rd[2], 64'h77);
    check("abort_rd_b3", rd[3], 64'h88);

    // Instance B: zero latency, 8 beats, back-to-back requests
    for (int k = 0; k < 8; k++) wd[k] = 64'(k + 1);
    xfer(1'b1, 1'b1, 32'h0000_0000, -1, -1, first_stb, n_stb, busy_fall);
    check("b_wb_first_stb", 64'(first_stb), 64'd1);
    check("b_wb_n_stb",     64'(n_stb),     64'd8);
    check("b_wb_busy_fall", 64'(busy_fall), 64'd9);
    xfer(1'b1, 1'b0, 32'h0000_0000, -1, -1, first_stb, n_stb, busy_fall);
    check("b_b2b_first_stb", 64'(first_stb), 64'd1);
    check("b_b2b_n_stb",     64'(n_stb),     64'd8);
    check("b_b2b_ovr", {63'd0, b_ovr}, 64'd0);
    for (int k = 0; k < 8; k++) check("b_rd0", rd[k], 64'(k + 1));
    xfer(1'b1, 1'b0, 32'h0000_0018, -1, -1, first_stb, n_stb, busy_fall);
    for (int k = 0; k < 8; k++) check("b_rd18", rd[k], 64'((k + 3) % 8 + 1));
`ifdef MEM_STATS_EN
    exp_rd = 64'd2; exp_wr = 64'd1;
`else
    exp_rd = 64'd0; exp_wr = 64'd0;
`endif
    check("b_stats_rd", {32'd0, b_rd_count}, exp_rd);
    check("b_stats_wr", {32'd0, b_wr_count}, exp_wr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Clocked main-memory responder for the L2-to-memory interface. It accepts line-fill and line-writeback requests from the L2 controller, waits a programmable access latency, then transfers one cache line as a burst of 64-bit beats, with a responder strobe per beat. It is the memory-side end of the protocol the L2 drives, synthesizable, with separate read and write data paths instead of a bidirectional bus.

## Interface
Parameters:
- LATENCY, 4: idle cycles between request capture and the first beat; 0 to 15.
- BEATS, 4: 64-bit beats per line; power of two, 2 to 8.
- DEPTH_LOG2, 10: log2 of the number of 64-bit words in the array.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- addrstb  in  1  request strobe from L2, one-cycle pulse; sampled only when busy=0.
- we  in  1  request type, sampled with addrstb: 1 = writeback, 0 = fill.
- addr  in  32  byte address, sampled with addrstb.
- wdata  in  64  write beat; sampled on every cycle with stb=1 during a writeback.
- rdata  out  64  read beat; valid only while stb=1 during a fill.
- stb  out  1  beat strobe: one cycle per beat transferred.
- busy  out  1  request in progress; addrstb is ignored while high.
- ovr  out  1  sticky flag: addrstb seen while busy=1.
- rd_count  out  32  completed fills (only with MEM_STATS_EN).
- wr_count  out  32  completed writebacks (only with MEM_STATS_EN).

## Operation
- Address decode: addr[2:0] is ignored. Word index is addr[DEPTH_LOG2+2:3]; upper bits are ignored, so the array aliases. The line base is the word index with its low log2(BEATS) bits cleared.
- Beat order is critical-word-first with wrap inside the line. Beat k uses word base + ((start + k) mod BEATS), where start is the low log2(BEATS) bits of the word index.
- FSM states:
  - IDLE: busy=0. When addrstb=1, latch we and the address and go to WAIT. With LATENCY=0, go directly to BURST.
  - WAIT: count LATENCY cycles, then go to BURST.
  - BURST: stb=1 for BEATS consecutive cycles.
    - Fill: rdata = word for the current beat.
    - Writeback: the word for the current beat is written with wdata at the end of the cycle. L2 must advance wdata after each stb.
    - After the last beat, go to IDLE.
- addrstb while busy=1: the request is dropped, ovr is set, and the FSM is unaffected. ovr clears only on reset.
- Reset (reset_n=0 at an edge):
  - Registered outputs after that edge: busy=0, stb=0, ovr=0, rdata=0, counters=0. State goes to IDLE.
  - The memory array is not cleared.
  - Reset mid-burst aborts the burst. Writeback beats already written remain in the array.
- Counters increment on the cycle of the last beat and wrap at 2^32.

## Timing
- addrstb is sampled at edge T. busy=1 from T to the end of the burst.
- First stb cycle starts at edge T+1+LATENCY. The last beat starts at T+LATENCY+BEATS.
- busy=0 starting the cycle after the last beat. A new addrstb is accepted in that cycle, so back-to-back requests have a gap of one idle cycle.
- rdata and stb are registered with zero skew: rdata changes only when stb changes or the beat advances.
- Read-after-write to the same word in consecutive requests returns the new data.

## Configuration
- MEM_STATS_EN defined: rd_count and wr_count are implemented as described.
- MEM_STATS_EN undefined: no counter registers exist, and rd_count and wr_count are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then a writeback to addr 0x0000_0040 with wdata 0x11, 0x22, 0x33, 0x44, LATENCY=4 -> stb high in cycles T+5..T+8; busy falls in cycle T+9. A fill to 0x40 then returns 0x11, 0x22, 0x33, 0x44 in order.
- Fill at addr 0x0000_0050 (word 10, start beat 2), after the line above is written -> rdata sequence 0x33, 0x44, 0x11, 0x22 (wrap).
- addrstb pulsed during WAIT of a fill -> ovr=1 and stays 1, exactly 4 stb cycles, no second burst. Reset clears ovr.
- reset_n low during the 3rd writeback beat at 0x80 -> stb=0 and busy=0 after that edge. A subsequent fill at 0x80 shows beats 0–1 new and beats 2–3 old.
- LATENCY=0, BEATS=8: fill at 0x0 -> stb in cycles T+1..T+8. A second addrstb is accepted at T+9 and its first stb is at T+10.
- With MEM_STATS_EN: 3 fills and 2 writebacks -> rd_count=3, wr_count=2. Without it, both read 0.
